// File: rtl/agu_pair_gen_k2.sv
// Radix-2 NTT butterfly index pair generator feeding the k2 order-translate stage.
// Walks every stage on a start pulse, one (Order_0, Order_1) pair per cycle, with
// a programmable idle gap between stages and a hold input that freezes the walk.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, hold           launch request (IDLE only), freeze request
//   Order_0, Order_1      butterfly index pair, zero-extended to D_WIDTH
//   r_enable_k2           pair valid; other pair outputs are zero when low
//   AGU_done_k2           final pair of the final stage
//   l                     stage index of the current pair
//   busy                  transform in flight
module agu_pair_gen_k2 #(
    parameter int LOGN      = 8,
    parameter int D_WIDTH   = 16,
    parameter int STAGE_GAP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic [D_WIDTH-1:0] Order_0,
    output logic [D_WIDTH-1:0] Order_1,
    output logic               r_enable_k2,
    output logic               AGU_done_k2,
    output logic [2:0]         l,
    output logic               busy
);

    localparam int BW = LOGN - 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    s_q, s_d;
    logic [BW-1:0] b_q, b_d;
    logic [GW-1:0] g_q, g_d;

    logic [D_WIDTH-1:0] o0_d, o1_d;
    logic               en_d, done_d, busy_d;
    logic [2:0]         l_d;

    logic [2:0]      pos;
    logic [LOGN-1:0] bx, bit_d, mask, pair_lo;
    logic            last_b, last_s, last_g;

    // Order_0 is b with a zero inserted at bit pos: bits below pos stay,
    // bits at and above pos move up by one. Order_1 sets that bit.
    assign pos     = 3'(LOGN - 1) - s_q;
    assign bx      = LOGN'(b_q);
    assign bit_d   = LOGN'(1) << pos;
    assign mask    = bit_d - LOGN'(1);
    assign pair_lo = (bx & mask) | ((bx & ~mask) << 1);

    assign last_b = (b_q == '1);
    assign last_s = (s_q == 3'(LOGN - 1));
    assign last_g = (g_q == GW'(STAGE_GAP - 1));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        g_d     = g_q;
        o0_d    = '0;
        o1_d    = '0;
        en_d    = 1'b0;
        done_d  = 1'b0;
        l_d     = '0;
        busy_d  = busy;
        unique case (state_q)
            IDLE: begin
                // busy still high here means the final pair was emitted last
                // cycle; a start in that cycle is dropped.
                busy_d = 1'b0;
                if (start && !busy) begin
                    state_d = RUN;
                    s_d     = '0;
                    b_d     = '0;
                    g_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (!hold) begin
                    o0_d   = D_WIDTH'(pair_lo);
                    o1_d   = D_WIDTH'(pair_lo | bit_d);
                    en_d   = 1'b1;
                    l_d    = s_q;
                    done_d = last_b && last_s;
                    b_d    = b_q + BW'(1);
                    if (last_b) begin
                        if (last_s) begin
                            state_d = IDLE;
                            s_d     = '0;
                        end else if (STAGE_GAP == 0) begin
                            s_d = s_q + 3'd1;
                        end else begin
                            state_d = GAP;
                            g_d     = '0;
                        end
                    end
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (!hold) begin
                    if (last_g) begin
                        state_d = RUN;
                        s_d     = s_q + 3'd1;
                        b_d     = '0;
                        g_d     = '0;
                    end else begin
                        g_d = g_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            b_q         <= '0;
            g_q         <= '0;
            Order_0     <= '0;
            Order_1     <= '0;
            r_enable_k2 <= 1'b0;
            AGU_done_k2 <= 1'b0;
            l           <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            b_q         <= b_d;
            g_q         <= g_d;
            Order_0     <= o0_d;
            Order_1     <= o1_d;
            r_enable_k2 <= en_d;
            AGU_done_k2 <= done_d;
            l           <= l_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_agu_pair_gen_k2.sv
// Bench for agu_pair_gen_k2: default instance (LOGN=8, gap 4) and a
// small corner instance (LOGN=2, gap 0), checked against a pair model.
module tb_agu_pair_gen_k2;

    logic        clk = 1'b0;
    logic        rst, start, hold;
    logic [15:0] Order_0, Order_1;
    logic        r_enable_k2, AGU_done_k2, busy;
    logic [2:0]  l;

    logic        rst2, start2, hold2;
    logic [15:0] o0b, o1b;
    logic        enb, doneb, busyb;
    logic [2:0]  lb;

    int n_checks = 0;
    int n_errors = 0;

    int exp_o0[$];
    int exp_o1[$];
    int exp_l[$];

    int obs_o0[1024];
    int obs_o1[1024];
    int obs_l[1024];

    always #5 clk = ~clk;

    agu_pair_gen_k2 #(.LOGN(8), .D_WIDTH(16), .STAGE_GAP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .Order_0(Order_0), .Order_1(Order_1),
        .r_enable_k2(r_enable_k2), .AGU_done_k2(AGU_done_k2),
        .l(l), .busy(busy)
    );

    agu_pair_gen_k2 #(.LOGN(2), .D_WIDTH(16), .STAGE_GAP(0)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .hold(hold2),
        .Order_0(o0b), .Order_1(o1b),
        .r_enable_k2(enb), .AGU_done_k2(doneb),
        .l(lb), .busy(busyb)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each stage pairs every index whose stage bit is clear with its partner
    // one stride up, in ascending order of the lower index.
    task automatic build_model(input int logn);
        exp_o0.delete();
        exp_o1.delete();
        exp_l.delete();
        for (int s = 0; s < logn; s++) begin
            int d;
            d = 1 << (logn - 1 - s);
            for (int i = 0; i < (1 << logn); i++) begin
                if ((i & d) == 0) begin
                    exp_o0.push_back(i);
                    exp_o1.push_back(i + d);
                    exp_l.push_back(s);
                end
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_noval", r_enable_k2, 0);
    endtask

    task automatic run_body(input bit use_hold, input bit poke_start,
                            input int stop_at, output int npairs,
                            output int first_cyc, output int done_cyc,
                            output int ngap4);
        int idx = 0;
        int gap = 0;
        int cyc = 0;
        int cnt;
        bit hold_v;
        bit final_held = 0;
        bit poked = 0;
        bit fin = 0;
        bit seen[256];
        npairs = 0;
        first_cyc = -1;
        done_cyc = -1;
        ngap4 = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        while (!fin && cyc < 4000) begin
            hold_v = use_hold &&
                     (($urandom_range(0, 3) == 0) ||
                      (idx == 1023 && !final_held));
            if (hold_v && idx == 1023) final_held = 1;
            hold = hold_v;
            start = poke_start && idx == 500 && !poked;
            if (start) poked = 1;
            @(posedge clk); #1;
            cyc++;
            hold = 1'b0;
            start = 1'b0;
            if (hold_v) chk("hold_inval", r_enable_k2, 0);
            chk("busy_run", busy, 1);
            if (!r_enable_k2) begin
                chk("zero_out", {Order_0, Order_1, l, AGU_done_k2}, 0);
                if (!hold_v) gap++;
            end else begin
                int eg;
                chk("o0", Order_0, exp_o0[idx]);
                chk("o1", Order_1, exp_o1[idx]);
                chk("l", l, exp_l[idx]);
                chk("done", AGU_done_k2, idx == 1023);
                chk("stride", Order_1 - Order_0, 1 << (7 - l));
                chk("range", Order_1 < 256, 1);
                eg = (idx > 0 && idx % 128 == 0) ? 4 : 0;
                chk("gap", gap, eg);
                if (eg == 4 && gap == 4) ngap4++;
                if (Order_1 < 256) begin
                    chk("cov_dup0", seen[Order_0[7:0]], 0);
                    chk("cov_dup1", seen[Order_1[7:0]], 0);
                    seen[Order_0[7:0]] = 1'b1;
                    seen[Order_1[7:0]] = 1'b1;
                end
                if (idx % 128 == 127) begin
                    cnt = 0;
                    foreach (seen[i]) begin
                        if (seen[i]) cnt++;
                        seen[i] = 1'b0;
                    end
                    chk("cov_stage", cnt, 256);
                end
                obs_o0[idx] = Order_0;
                obs_o1[idx] = Order_1;
                obs_l[idx] = l;
                if (first_cyc < 0) first_cyc = cyc;
                npairs++;
                idx++;
                gap = 0;
                if (AGU_done_k2) done_cyc = cyc;
                if (AGU_done_k2 || idx == 1024) fin = 1;
                if (stop_at >= 0 && idx > stop_at) fin = 1;
            end
        end
        chk("timeout", fin, 1);
    endtask

    initial begin
        int np, fc, dc, ng, cnt2, cyc2;
        int c2_o0[4];
        int c2_o1[4];
        c2_o0 = '{0, 1, 0, 2};
        c2_o1 = '{2, 3, 1, 3};
        foreach (obs_o0[i]) begin
            obs_o0[i] = 0; obs_o1[i] = 0; obs_l[i] = 0;
        end
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; hold2 = 1'b0;
        build_model(8);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {Order_0, Order_1, l, AGU_done_k2, r_enable_k2, busy}, 0);
        rst = 1'b0;
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // plain run
        do_start();
        run_body(0, 0, -1, np, fc, dc, ng);
        chk("npairs", np, 1024);
        chk("latency", fc, 1);
        chk("span", dc - fc + 1, 1052);
        chk("ngaps", ng, 7);
        chk("first_pair", {obs_o0[0], obs_o1[0], obs_l[0]}, {32'd0, 32'd128, 32'd0});
        chk("s0_b5", {obs_o0[5], obs_o1[5]}, {32'd5, 32'd133});
        chk("s3_b37", {obs_o0[421], obs_o1[421], obs_l[421]}, {32'd69, 32'd85, 32'd3});
        chk("s7_b5", {obs_o0[901], obs_o1[901], obs_l[901]}, {32'd10, 32'd11, 32'd7});
        chk("final", {obs_o0[1023], obs_o1[1023], obs_l[1023]}, {32'd254, 32'd255, 32'd7});

        // start in the done cycle is dropped, the next one launches
        start = 1'b1;
        @(posedge clk); #1;
        chk("end_busy_fall", busy, 0);
        chk("end_noval", r_enable_k2, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_noval", r_enable_k2, 0);

        // second transform with random hold and a stray start
        run_body(1, 1, -1, np, fc, dc, ng);
        chk("hold_npairs", np, 1024);
        chk("hold_ngaps", ng, 7);
        chk("hold_done", dc > 0, 1);

        @(posedge clk); #1;
        chk("idle2_busy", busy, 0);

        // reset in the middle of a run
        do_start();
        run_body(0, 0, 300, np, fc, dc, ng);
        chk("pre_rst_npairs", np, 301);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out", {Order_0, Order_1, l, AGU_done_k2, r_enable_k2, busy}, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", {r_enable_k2, busy}, 0);
        end
        do_start();
        run_body(0, 0, -1, np, fc, dc, ng);
        chk("restart_npairs", np, 1024);
        chk("restart_first", {obs_o0[0], obs_o1[0]}, {32'd0, 32'd128});

        // LOGN=2, no gap
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cnt2 = 0;
        cyc2 = 0;
        while (cyc2 < 20) begin
            @(posedge clk); #1;
            cyc2++;
            if (enb) begin
                if (cnt2 < 4) begin
                    chk("c2_o0", o0b, c2_o0[cnt2]);
                    chk("c2_o1", o1b, c2_o1[cnt2]);
                    chk("c2_l", lb, cnt2 / 2);
                    chk("c2_done", doneb, cnt2 == 3);
                    chk("c2_cyc", cyc2, cnt2 + 1);
                end
                cnt2++;
            end else begin
                chk("c2_zero", {o0b, o1b, lb, doneb}, 0);
            end
        end
        chk("c2_count", cnt2, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
